// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//
// Shares the single write port (WEN/RW/busW) of an 8x8 register file between
// two requesters, A and B. Each requester owns a one-deep holding buffer
// with a valid/ready handshake. When both buffers are full, a round-robin
// pointer resolves the conflict.
//
// Optional feature macro: RF_ARB_INIT_EN
//   defined   : after reset, an init sweep writes 8'h00 to registers 0..7
//               before any request is accepted (init_busy high meanwhile).
//   undefined : reset goes straight to arbitration and init_busy is tied 0.
//
// Ports
//   Clk               clock, all state updates on posedge
//   Rst               synchronous active-high reset
//   a_valid/a_ready   requester A handshake (accept = valid && ready)
//   a_addr/a_data     requester A write address / data
//   b_*               same set for requester B
//   WEN/RW/busW       register-file write enable / address / data
//   grant_a/grant_b   the current WEN cycle carries A's / B's buffered write
//   init_busy         init sweep in progress
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
   parameter int AW = 3,
   parameter int DW = 8
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_data,
   input  logic          b_valid,
   output logic          b_ready,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_data,
   output logic          WEN,
   output logic [AW-1:0] RW,
   output logic [DW-1:0] busW,
   output logic          grant_a,
   output logic          grant_b,
   output logic          init_busy
);

   // Requester index 0 = A, 1 = B.
   logic [1:0]    req_valid;
   logic [AW-1:0] req_addr [2];
   logic [DW-1:0] req_data [2];
   logic [1:0]    req_ready;
   logic [1:0]    sel;
   logic [1:0]    accept;

   logic [1:0]    hold_full_q, hold_full_d;
   logic [AW-1:0] hold_addr_q [2];
   logic [DW-1:0] hold_data_q [2];
   logic          prio_q, prio_d;   // 0 = A preferred, 1 = B preferred
   logic          in_arb;

   assign req_valid   = {b_valid, a_valid};
   assign req_addr[0] = a_addr;
   assign req_addr[1] = b_addr;
   assign req_data[0] = a_data;
   assign req_data[1] = b_data;

`ifdef RF_ARB_INIT_EN
   localparam logic [0:0] MODE_INIT = 1'b0;
   localparam logic [0:0] MODE_ARB  = 1'b1;

   logic [0:0]    mode_q, mode_d;
   logic [AW-1:0] cnt_q, cnt_d;

   assign in_arb = (mode_q == MODE_ARB);

   always_comb begin
      mode_d = mode_q;
      cnt_d  = cnt_q;
      if (mode_q == MODE_INIT) begin
         cnt_d = cnt_q + AW'(1);
         if (cnt_q == {AW{1'b1}}) begin
            mode_d = MODE_ARB;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         mode_q <= MODE_INIT;
         cnt_q  <= '0;
      end else begin
         mode_q <= mode_d;
         cnt_q  <= cnt_d;
      end
   end

   assign init_busy = ~in_arb;
`else
   assign in_arb    = 1'b1;
   assign init_busy = 1'b0;
`endif

   // Arbitration. Everything here is decoded from registered state only, so
   // there is no combinational path from a_valid/b_valid to WEN. Rst gates
   // grants and readies directly so nothing moves while reset is held.
   always_comb begin
      sel[0] = in_arb && !Rst && hold_full_q[0] && (!hold_full_q[1] || !prio_q);
      sel[1] = in_arb && !Rst && hold_full_q[1] && !sel[0];
   end

   // Per-requester handshake and hold next-state. A hold that is granted this
   // cycle frees up at the same edge, so it can take a new request at once
   // (this allows streaming at one write per cycle).
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         assign req_ready[gi]   = in_arb && !Rst && (!hold_full_q[gi] || sel[gi]);
         assign accept[gi]      = req_valid[gi] && req_ready[gi];
         assign hold_full_d[gi] = accept[gi] || (hold_full_q[gi] && !sel[gi]);
      end
   endgenerate

   // After a grant the other requester gets preference. Without a grant the
   // pointer is left alone.
   always_comb begin
      prio_d = prio_q;
      if (sel[0]) begin
         prio_d = 1'b1;
      end else if (sel[1]) begin
         prio_d = 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         hold_full_q <= '0;
         prio_q      <= 1'b0;
      end else begin
         hold_full_q <= hold_full_d;
         prio_q      <= prio_d;
      end
   end

   // Hold payload needs no reset because it is qualified by hold_full_q.
   always_ff @(posedge Clk) begin
      for (int i = 0; i < 2; i++) begin
         if (accept[i]) begin
            hold_addr_q[i] <= req_addr[i];
            hold_data_q[i] <= req_data[i];
         end
      end
   end

   // Write port mux. The address and data read 0 whenever WEN is low.
   always_comb begin
      WEN  = 1'b0;
      RW   = '0;
      busW = '0;
      if (!Rst && !in_arb) begin
`ifdef RF_ARB_INIT_EN
         WEN = 1'b1;
         RW  = cnt_q;
`endif
      end else if (sel[0]) begin
         WEN  = 1'b1;
         RW   = hold_addr_q[0];
         busW = hold_data_q[0];
      end else if (sel[1]) begin
         WEN  = 1'b1;
         RW   = hold_addr_q[1];
         busW = hold_data_q[1];
      end
   end

   assign grant_a = sel[0];
   assign grant_b = sel[1];
   assign a_ready = req_ready[0];
   assign b_ready = req_ready[1];

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_write_arbiter
//
// Self-checking bench for rf_write_arbiter. A behavioural model keeps each
// requester's pending writes in a queue, tracks which requester is owed the
// next turn, and tracks how many init cycles remain. Every cycle the bench
// compares the DUT's outputs against that model. A shadow register file
// (written from the DUT port) is compared with the model's register file.
// Works with or without RF_ARB_INIT_EN.
// ---------------------------------------------------------------------------
module tb_rf_write_arbiter;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       a_valid = 1'b0, b_valid = 1'b0;
   logic [2:0] a_addr = '0, b_addr = '0;
   logic [7:0] a_data = '0, b_data = '0;
   logic       a_ready, b_ready, WEN, grant_a, grant_b, init_busy;
   logic [2:0] RW;
   logic [7:0] busW;

   rf_write_arbiter #(.AW(3), .DW(8)) dut (
      .Clk(Clk), .Rst(Rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .WEN(WEN), .RW(RW), .busW(busW),
      .grant_a(grant_a), .grant_b(grant_b), .init_busy(init_busy)
   );

   always #5 Clk = ~Clk;

`ifdef RF_ARB_INIT_EN
   localparam int INIT_CYCLES = 8;
`else
   localparam int INIT_CYCLES = 0;
`endif

   typedef struct packed {
      logic [2:0] addr;
      logic [7:0] data;
   } wr_t;

   // Reference model state
   wr_t        q_a[$];
   wr_t        q_b[$];
   bit         b_turn = 1'b0;      // B is owed the next contested grant
   int         init_left = 0;
   logic [7:0] rf_model [8];
   logic [7:0] rf_seen  [8];

   // Expected outputs for the current cycle
   bit         e_wen, e_ga, e_gb, e_ra, e_rb, e_busy;
   logic [2:0] e_rw;
   logic [7:0] e_busw;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
   endtask

   // Shadow register file driven by the DUT's write port.
   always @(posedge Clk) begin
      if (WEN === 1'b1) rf_seen[RW] <= busW;
   end

   function automatic void compute_expected();
      e_wen = 0; e_ga = 0; e_gb = 0; e_ra = 0; e_rb = 0;
      e_rw = '0; e_busw = '0; e_busy = (init_left > 0);
      if (Rst) return;
      if (init_left > 0) begin
         e_wen = 1;
         e_rw  = 3'(INIT_CYCLES - init_left);
         return;
      end
      e_ga = (q_a.size() > 0) && (q_b.size() == 0 || !b_turn);
      e_gb = (q_b.size() > 0) && !e_ga;
      e_wen = e_ga || e_gb;
      if (e_ga) begin e_rw = q_a[0].addr; e_busw = q_a[0].data; end
      if (e_gb) begin e_rw = q_b[0].addr; e_busw = q_b[0].data; end
      e_ra = (q_a.size() == 0) || e_ga;
      e_rb = (q_b.size() == 0) || e_gb;
   endfunction

   function automatic void update_model();
      if (Rst) begin
         q_a.delete();
         q_b.delete();
         b_turn    = 1'b0;
         init_left = INIT_CYCLES;
         return;
      end
      if (init_left > 0) begin
         rf_model[INIT_CYCLES - init_left] = 8'h00;
         init_left--;
         return;
      end
      if (e_ga) begin
         rf_model[q_a[0].addr] = q_a[0].data;
         void'(q_a.pop_front());
         b_turn = 1'b1;
      end
      if (e_gb) begin
         rf_model[q_b[0].addr] = q_b[0].data;
         void'(q_b.pop_front());
         b_turn = 1'b0;
      end
      if (a_valid && e_ra) q_a.push_back({a_addr, a_data});
      if (b_valid && e_rb) q_b.push_back({b_addr, b_data});
   endfunction

   // One clock cycle: check at negedge, advance the model at posedge, and
   // return 1 time unit later so the caller can drive the next inputs.
   task automatic step();
      @(negedge Clk);
      compute_expected();
      check_val("WEN",     32'(WEN),     32'(e_wen));
      check_val("grant_a", 32'(grant_a), 32'(e_ga));
      check_val("grant_b", 32'(grant_b), 32'(e_gb));
      check_val("a_ready", 32'(a_ready), 32'(e_ra));
      check_val("b_ready", 32'(b_ready), 32'(e_rb));
      if (!Rst) begin
         check_val("init_busy", 32'(init_busy), 32'(e_busy));
         check_val("RW",        32'(RW),        32'(e_rw));
         check_val("busW",      32'(busW),      32'(e_busw));
      end
      $display("t=%0t rst=%0b av=%0b bv=%0b WEN=%0b RW=%0d busW=%02h ga=%0b gb=%0b ar=%0b br=%0b ib=%0b",
               $time, Rst, a_valid, b_valid, WEN, RW, busW, grant_a, grant_b, a_ready, b_ready, init_busy);
      @(posedge Clk);
      update_model();
      #1;
   endtask

   task automatic drive(input bit va, input logic [2:0] aa, input logic [7:0] da,
                        input bit vb, input logic [2:0] ab, input logic [7:0] db);
      a_valid = va; a_addr = aa; a_data = da;
      b_valid = vb; b_addr = ab; b_data = db;
   endtask

   task automatic idle(input int n);
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      step();
      Rst = 1'b0;
   endtask

   initial begin
      logic [7:0] stream_d [3];
      int na, nb;
      stream_d[0] = 8'h11; stream_d[1] = 8'h22; stream_d[2] = 8'h33;
      for (int i = 0; i < 8; i++) begin rf_model[i] = 8'h00; rf_seen[i] = 8'h00; end

      // Reset, then the init sweep (if compiled in), then idle ARB.
      Rst = 1'b1;
      step();
      step();
      Rst = 1'b0;
      idle(INIT_CYCLES + 2);

      // Single requester: one write, then a three-write stream.
      drive(1, 3'd3, 8'h5A, 0, 0, 0);
      step();
      idle(1);
      for (int i = 0; i < 3; i++) begin
         drive(1, 3'(i), stream_d[i], 0, 0, 0);
         step();
      end
      idle(3);
      check_val("rf3_readback", 32'(rf_seen[3]), 32'h5A);
      check_val("rf2_readback", 32'(rf_seen[2]), 32'h33);

      // Contention: both requesters valid every cycle; each advances only
      // when the model says its request was accepted.
      na = 0; nb = 0;
      for (int i = 0; i < 10; i++) begin
         drive(1, 3'(na), 8'(8'hA0 + na), 1, 3'(4 + (nb % 4)), 8'(8'hB0 + nb));
         step();
         if (e_ra) na++;
         if (e_rb) nb++;
      end
      idle(3);

      // Same address from both requesters in one cycle with prio back at A.
      do_reset();
      idle(INIT_CYCLES + 1);
      drive(1, 3'd5, 8'hAA, 1, 3'd5, 8'h55);
      step();
      idle(3);
      check_val("rf5_later_grant_wins", 32'(rf_seen[5]), 32'h55);

      // Reset while both holds are full: the held writes must never appear.
      drive(1, 3'd1, 8'hC1, 1, 3'd2, 8'hC2);
      step();
      do_reset();
      idle(INIT_CYCLES + 2);
      check_val("rf1_discarded", 32'(rf_seen[1] == 8'hC1), 32'd0);
      // prio must be back at A after reset.
      drive(1, 3'd6, 8'h61, 1, 3'd6, 8'h62);
      step();
      idle(3);
      check_val("rf6_prio_after_reset", 32'(rf_seen[6]), 32'h62);

      // Lone requester writing the top register.
      drive(1, 3'd7, 8'hFF, 0, 0, 0);
      step();
      idle(2);
      check_val("rf7_readback", 32'(rf_seen[7]), 32'hFF);

      // Randomized traffic with occasional resets. Each requester keeps its
      // request stable until it is accepted, or drops it now and then.
      for (int i = 0; i < 600; i++) begin
         Rst = ($urandom_range(0, 149) == 0);
         if (!a_valid || e_ra || $urandom_range(0, 9) == 0) begin
            a_valid = ($urandom_range(0, 99) < 65);
            a_addr  = 3'($urandom_range(0, 7));
            a_data  = 8'($urandom);
         end
         if (!b_valid || e_rb || $urandom_range(0, 9) == 0) begin
            b_valid = ($urandom_range(0, 99) < 65);
            b_addr  = 3'($urandom_range(0, 7));
            b_data  = 8'($urandom);
         end
         step();
      end
      Rst = 1'b0;
      idle(INIT_CYCLES + 4);

      for (int i = 0; i < 8; i++) begin
         check_val($sformatf("rf_final[%0d]", i), 32'(rf_seen[i]), 32'(rf_model[i]));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
